// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the BCD seven-segment readout.
// Patterns are {g,f,e,d,c,b,a}, active-low, for a common-anode display.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [23:0] bcd_word_t;
  typedef logic [6:0]  seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Codes 10..15 are not valid BCD and are shown as a dash.
module bcd_seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else if (i_nibble <= 4'd9) begin
      o_seg = SEG_DIGIT[i_nibble];
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Six-digit time-multiplexed seven-segment scanner with frame-aligned update.
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [23:0]           bcd,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame
);

  localparam int                PCNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(CLK_DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]     r_pcnt;
  logic [2:0]            r_idx;
  logic [23:0]           r_pend;
  logic                  r_pend_v;
  logic [23:0]           r_disp;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;

  logic                  w_tick;
  logic                  w_wrap;
  logic [2:0]            w_idx_next;
  logic [23:0]           w_disp_next;
  logic [23:0]           w_pend_next;
  logic                  w_pend_v_next;
  logic [3:0]            w_nibble;
  logic                  w_blank;
  logic [6:0]            w_seg;

  assign w_tick = (r_pcnt == PCNT_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  always_comb begin
    w_idx_next = r_idx;
    if (w_wrap) begin
      w_idx_next = 3'd0;
    end else if (w_tick) begin
      w_idx_next = r_idx + 3'd1;
    end
  end

  // A load landing on the wrap edge bypasses pend and goes live immediately.
  always_comb begin
    w_disp_next   = r_disp;
    w_pend_next   = r_pend;
    w_pend_v_next = r_pend_v;
    if (w_wrap) begin
      if (load) begin
        w_disp_next = bcd;
      end else if (r_pend_v) begin
        w_disp_next = r_pend;
      end
      w_pend_v_next = 1'b0;
    end else if (load) begin
      w_pend_next   = bcd;
      w_pend_v_next = 1'b1;
    end
  end

  // Outputs are registered from next-state values so seg/an/frame line up.
  assign w_nibble = w_disp_next[{w_idx_next, 2'b00} +: 4];

`ifdef BCD_SCAN_LZB_EN
  logic [NUM_DIGITS:0] w_zero_above;
  assign w_zero_above[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
    assign w_zero_above[gi] = w_zero_above[gi+1] && (w_disp_next[4*gi +: 4] == 4'd0);
  end
  assign w_blank = (w_idx_next != 3'd0) && w_zero_above[w_idx_next];
`else
  assign w_blank = 1'b0;
`endif

  bcd_seg7_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt   <= '0;
      r_idx    <= 3'd0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_disp   <= '0;
      r_seg    <= SEG_BLANK;
      r_an     <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_pcnt   <= w_tick ? '0 : r_pcnt + PCNT_W'(1);
      r_idx    <= w_idx_next;
      r_pend   <= w_pend_next;
      r_pend_v <= w_pend_v_next;
      r_disp   <= w_disp_next;
      r_seg    <= w_seg;
      r_an     <= ~(NUM_DIGITS'(1) << w_idx_next);
      r_frame  <= w_wrap;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign frame = r_frame;

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed seven-segment driver that consumes the 24-bit, six-digit BCD word produced by the binary-to-BCD converter and scans it onto a common-anode display one digit at a time. A new BCD value is captured on a load strobe, held in a pending register, and committed to the display only at a frame boundary, so a frame never mixes old and new digits. It sits directly downstream of the converter, at the score/readout output of the design.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- NUM_DIGITS, 6: digits scanned; fixed at 6 to match the 24-bit BCD word.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- bcd  in  24  BCD word `{d5,d4,d3,d2,d1,d0}`; d0 is `bcd[3:0]` (ones).
- load  in  1  single-cycle strobe; samples `bcd` this cycle.
- seg  out  7  segments `{g,f,e,d,c,b,a}`, active-low, registered.
- an  out  6  digit enables, active-low, one-hot-low, registered; `an[0]` = ones digit.
- frame  out  1  one-cycle pulse on each frame wrap (digit 5 → digit 0).

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 and wraps.
  - `tick` is asserted when `pcnt == CLK_DIV-1`.
- Digit index `idx` advances on `tick`: 0→1→…→5→0.
  - Wrap condition: `tick && idx == 5`.
- Pending register: `load` writes `bcd` into `pend` and sets `pend_v`.
  - A later `load` before commit overwrites `pend`; only the last value is kept.
- Commit, on frame wrap:
  - If `pend_v` is set: `disp <= pend`, then clear `pend_v`.
  - If `load` is asserted in the same cycle as the wrap, the incoming `bcd` goes straight to `disp`, bypassing `pend`, and `pend_v` is cleared.
- Per-digit decode of nibble n = `disp[4*idx +: 4]`:
  - 0..9: standard patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - 10..15 (invalid BCD): dash, only segment g lit = 7'b0111111.
- Blanked digit: `seg` = 7'b1111111; `an` is still driven for that slot (keeps duty cycle uniform).
- The module has no state machine beyond `pcnt`, `idx`, `pend_v`. All state is counter or register based.

## Timing
- Reset values:
  - `pcnt` = 0, `idx` = 0, `pend` = 0, `pend_v` = 0, `disp` = 0.
  - `seg` = 7'h7F, `an` = 6'h3F (all off), `frame` = 0.
- First digit enable appears one cycle after reset deasserts: `an` = 6'b111110, showing digit 0 of `disp` = 0.
- `seg` and `an` update on the cycle after `tick`; both change on the same edge.
- `frame` is high in the cycle after the wrap tick, aligned with `an` = 6'b111110.
- Latency from `load` to visible change:
  - Minimum 1 cycle (load coincident with wrap).
  - Maximum 6·CLK_DIV cycles.
- Reset asserted mid-frame:
  - Next edge returns every register to its reset value.
  - A pending value is discarded.

## Configuration
- `BCD_SCAN_LZB_EN` defined: leading-zero blanking.
  - A digit k > 0 is blanked when it and every digit above it are 0.
  - Digit 0 is never blanked.
  - Invalid nibbles count as non-zero.
- Undefined: all six digits always shown (000042 displays as six lit digits).

## Structure
- Package `bcd_disp_pkg`:
  - `NUM_DIGITS`
  - segment constants `SEG_BLANK`, `SEG_DASH`, `SEG_DIGIT[0:9]`
  - typedef `bcd_word_t` (logic [23:0])
  - typedef `seg_t` (logic [6:0])
- Sub-module `bcd_seg7_decode`: combinational nibble + blank → `seg_t`. It is reused by any other readout in the design.

## Test plan
- Reset with CLK_DIV=4, then release reset → `an` cycles 3E,3D,3B,37,2F,1F, each for 4 cycles; `seg` = 7'h40 throughout (LZB off); `frame` pulses every 24 cycles.
- `load` with `bcd` = 24'h123456 mid-frame → `seg`/`an` unchanged until the wrap; next frame shows digits 6,5,4,3,2,1 on `an[0]`..`an[5]`.
- Two loads in one frame (24'h000111, then 24'h000999) → only 999 is ever displayed.
- `load` with `bcd` = 24'h000042 in the wrap cycle → digit 0 shows 2 the next cycle.
  - With `BCD_SCAN_LZB_EN`: digits 2..5 are `seg` = 7'h7F.
- `bcd` = 24'h00000A loaded → digit 0 shows 7'b0111111 (dash).
- `reset` asserted while `pend_v` = 1 → `an` = 3F and `seg` = 7F next cycle; after release the display shows 0, not the pending value.
